mem_read_sequencer: RTL and testbench

- Read-side counterpart to the write address counter. It drains a buffer of up to DEPTH entries that the write side has filled.
- On a start pulse it issues sequential read addresses from base_i to a synchronous-read memory (1-cycle latency).
- Returned words go out on a valid/ready stream, so downstream stalls never drop data.
- Sits between the shared data memory and the downstream consumer.

---
 rtl/mem_read_sequencer_pkg.sv | 18 +
 rtl/mem_read_sequencer_rd_skid_buf.sv | 77 +++++++
 rtl/mem_read_sequencer.sv | 135 +++++++++++++
 tb/tb_mem_read_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_read_sequencer_pkg.sv
// Shared definitions for the read-side sequencer. The write-side address
// counter reuses the default width/depth constants.
package mem_read_sequencer_pkg;

    // Default sizing shared by the read and write sides of the buffer.
    localparam int unsigned DEFAULT_CNT_WIDTH  = 7;
    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 100;

    // Read sequencer control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

endpackage : mem_read_sequencer_pkg

// File: rtl/mem_read_sequencer_rd_skid_buf.sv
// Two-entry FIFO that absorbs memory read data so downstream stalls never
// lose a word that is already in flight.
module rd_skid_buf
    import mem_read_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full buffer is only legal when the head leaves this cycle.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Entry storage written at the write pointer.
    // NOTE: storage is reset here because data_o must read 0 out of reset; a
    // deep RAM would normally be left unreset and qualified by valid instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointer and occupancy registers.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Occupancy update; simultaneous push and pop leaves it unchanged.
    // NOTE: default assigned first so no path leaves count_d unassigned (no latch).
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

endmodule : rd_skid_buf

// File: rtl/mem_read_sequencer.sv
// Read sequencer: drains a burst of sequential addresses from a 1-cycle
// synchronous-read memory and presents the words on a valid/ready stream.
module mem_read_sequencer
    import mem_read_sequencer_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [CNT_WIDTH-1:0]  base_i,
    input  logic [CNT_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_rd_en_o,
    output logic [CNT_WIDTH-1:0]  mem_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    // Wrap happens at the last legal buffer address, not at the counter limit.
    localparam logic [CNT_WIDTH-1:0] LAST_ADDR = CNT_WIDTH'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);

    rd_state_e             state_q;
    rd_state_e             state_d;
    logic [CNT_WIDTH-1:0]  addr_q;
    logic [CNT_WIDTH-1:0]  addr_d;
    logic [CNT_WIDTH-1:0]  remain_q;
    logic [CNT_WIDTH-1:0]  remain_d;
    logic                  inflight_q;

    logic                  issue;
    logic                  pop;
    logic [1:0]            buf_count;
    logic                  buf_full;
    logic                  buf_empty;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [1:0]            occ_after_pop;
    logic [2:0]            outstanding;

    // Words owed downstream once this cycle's handshake is accounted for:
    // what stays in the buffer plus the read whose data lands this cycle.
    // Counting the pop keeps one word per cycle with ready_i held high while
    // still never letting more than two words be outstanding.
    assign pop           = valid_o && ready_i;
    assign occ_after_pop = buf_count - {1'b0, pop};
    assign outstanding   = {1'b0, occ_after_pop} + {2'b00, inflight_q};

    // A full buffer that is not draining can never accept another word.
    assign issue = (state_q == ST_READ) && (remain_q != '0) &&
                   (outstanding < 3'd2) && !(buf_full && !pop);

    assign busy_o        = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done_o        = (state_q == ST_DONE);
    assign mem_rd_en_o   = issue;
    assign mem_rd_addr_o = addr_q;
    assign valid_o       = !buf_empty;
    assign data_o        = buf_head;

    // Control state, address, remaining count and in-flight flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= issue;
        end
    end

    // Next-state logic: burst launch, read issue with wrap, drain and done.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != '0) begin
                        addr_d   = base_i;
                        remain_d = len_i;
                        state_d  = ST_READ;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_READ: begin
                if (issue) begin
                    addr_d   = (addr_q == LAST_ADDR) ? '0 : addr_q + ONE;
                    remain_d = remain_q - ONE;
                    if (remain_q == ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && buf_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data is captured the cycle after its issue.
    rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i (mem_rd_data_i),
        .pop_i       (pop),
        .head_o      (buf_head),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

endmodule : mem_read_sequencer

// File: tb/tb_mem_read_sequencer.sv
// Scoreboard bench for mem_read_sequencer: the driver pushes the expected
// address/data sequence of each burst, a monitor pops and compares whenever
// the DUT issues a read or completes a handshake.
module tb_mem_read_sequencer;

    localparam int DEPTH = 100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic [6:0] base_i;
    logic [6:0] len_i;
    logic       busy_o;
    logic       done_o;
    logic       mem_rd_en_o;
    logic [6:0] mem_rd_addr_o;
    logic [7:0] mem_rd_data_i = 8'h00;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;

    int tests_run = 0;
    int failed    = 0;

    logic [7:0] mem [0:127];
    logic [6:0] exp_addr_q [$];
    logic [7:0] exp_data_q [$];

    always #5 clk = ~clk;

    mem_read_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .base_i        (base_i),
        .len_i         (len_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .mem_rd_en_o   (mem_rd_en_o),
        .mem_rd_addr_o (mem_rd_addr_o),
        .mem_rd_data_i (mem_rd_data_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i)
    );

    // Synchronous-read memory, one cycle of latency.
    always @(posedge clk) begin
        if (mem_rd_en_o) mem_rd_data_i <= mem[mem_rd_addr_o];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"},  busy_o,        0);
        check({tag, "_done"},  done_o,        0);
        check({tag, "_rd_en"}, mem_rd_en_o,   0);
        check({tag, "_addr"},  mem_rd_addr_o, 0);
        check({tag, "_valid"}, valid_o,       0);
        check({tag, "_data"},  data_o,        0);
    endtask

    function automatic logic ready_pat(input int mode, input int k);
        logic [5:0] pat;
        pat = 6'b101001;  // 1,0,0,1,0,1 from bit 0 upward
        case (mode)
            0:       return 1'b1;
            1:       return pat[k % 6];
            default: return ($urandom_range(0, 3) != 0);
        endcase
    endfunction

    // Monitor: compares every issued address and every accepted word against
    // the scoreboard, checks stall stability and the two-word outstanding limit.
    initial begin
        int         outstanding;
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       hs;
        outstanding = 0;
        prev_stall  = 1'b0;
        prev_data   = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                outstanding = 0;
                prev_stall  = 1'b0;
            end else begin
                hs = valid_o && ready_i;
                if (prev_stall) begin
                    check("stall_valid", valid_o, 1);
                    check("stall_data",  data_o,  prev_data);
                end
                if (mem_rd_en_o) begin
                    check("issue_room", ((outstanding - int'(hs)) < 2), 1);
                    if (exp_addr_q.size() == 0) begin
                        tests_run++;
                        failed++;
                        $display("FAIL unexpected_read: addr %0d issued, none expected (t=%0t)", mem_rd_addr_o, $time);
                    end else begin
                        check("rd_addr", mem_rd_addr_o, exp_addr_q.pop_front());
                    end
                end
                if (hs) begin
                    if (exp_data_q.size() == 0) begin
                        tests_run++;
                        failed++;
                        $display("FAIL unexpected_word: data %0h accepted, none expected (t=%0t)", data_o, $time);
                    end else begin
                        check("stream_data", data_o, exp_data_q.pop_front());
                    end
                end
                outstanding = outstanding + int'(mem_rd_en_o) - int'(hs);
                prev_stall  = valid_o && !ready_i;
                prev_data   = data_o;
            end
        end
    end

    // One burst: fill memory, queue expectations, pulse start, then watch
    // latency, busy and done. abort_after > 0 resets after that many words.
    task automatic run_burst(input int base, input int len, input int rmode,
                             input logic [7:0] salt, input int abort_after,
                             input bit mid_start);
        int k;
        int n_hs;
        int first_valid_k;
        int last_hs_k;
        int busy_bad;
        int quiet_bad;
        bit done_seen;
        for (int a = 0; a < 128; a++) mem[a] = 8'(a + 16) ^ salt;
        for (int i = 0; i < len; i++) begin
            int a;
            a = (base + i) % DEPTH;
            exp_addr_q.push_back(7'(a));
            exp_data_q.push_back(mem[a]);
        end
        @(posedge clk); #1;
        start_i = 1'b1;
        base_i  = 7'(base);
        len_i   = 7'(len);
        ready_i = 1'b1;
        @(posedge clk); #1;
        // Scramble the request fields to show they were latched with start.
        start_i = 1'b0;
        base_i  = 7'($urandom);
        len_i   = 7'($urandom);
        ready_i = ready_pat(rmode, 0);
        n_hs = 0; first_valid_k = -1; last_hs_k = -1; busy_bad = 0; done_seen = 0;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (valid_o && first_valid_k < 0) first_valid_k = k;
            if (valid_o && ready_i) begin
                n_hs++;
                last_hs_k = k;
            end
            if (done_o) begin
                done_seen = 1'b1;
                break;
            end
            if (busy_o !== 1'b1) busy_bad++;
            if (abort_after > 0 && n_hs == abort_after) begin
                #2;
                rst_n = 1'b0;
                #1;
                check_outputs_zero("abort");
                exp_addr_q.delete();
                exp_data_q.delete();
                start_i = 1'b0;
                @(posedge clk);
                @(posedge clk); #1;
                rst_n = 1'b1;
                quiet_bad = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (done_o || busy_o || mem_rd_en_o || valid_o) quiet_bad++;
                end
                check("abort_idle_after_release", quiet_bad, 0);
                return;
            end
            @(posedge clk); #1;
            ready_i = ready_pat(rmode, k + 1);
            if (mid_start && k == 1) begin
                start_i = 1'b1;
                base_i  = 7'd50;
                len_i   = 7'd7;
            end else begin
                start_i = 1'b0;
            end
        end
        check("done_seen",         done_seen, 1);
        check("busy_during_burst", busy_bad,  0);
        check("handshakes",        n_hs,      len);
        if (len != 0) begin
            // Start sampled at edge 0; READ issues, memory returns, buffer captures.
            check("first_valid_lat", first_valid_k, 2);
            // The final pop lands at the next edge; DRAIN then sees the buffer
            // empty and moves to DONE one edge later.
            check("done_lat", k, last_hs_k + 2);
            if (rmode == 0) check("back_to_back", last_hs_k - first_valid_k, len - 1);
        end else begin
            check("zero_len_done_lat", k, 0);
        end
        check("busy_at_done",       busy_o, 0);
        check("scoreboard_drained", exp_addr_q.size() + exp_data_q.size(), 0);
        @(negedge clk);
        check("done_single_pulse", done_o, 0);
        check("busy_after_done",   busy_o, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        base_i  = '0;
        len_i   = '0;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        run_burst(0,  4,   0, 8'h00, 0, 0);                 // basic: 10,11,12,13
        run_burst(98, 4,   0, 8'($urandom), 0, 0);          // wrap 98,99,0,1
        run_burst(0,  6,   1, 8'($urandom), 0, 0);          // backpressure
        run_burst(95, 10,  1, 8'($urandom), 0, 0);          // backpressure across wrap
        run_burst(20, 0,   0, 8'($urandom), 0, 0);          // zero length
        run_burst(30, 3,   0, 8'($urandom), 0, 1);          // start ignored mid-burst
        run_burst(40, 5,   0, 8'($urandom), 2, 0);          // reset after 2 of 5
        run_burst(10, 2,   0, 8'($urandom), 0, 0);          // recovery burst
        run_burst(0,  100, 0, 8'($urandom), 0, 0);          // full range
        repeat (6) begin
            run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 20)),
                      2, 8'($urandom), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule : tb_mem_read_sequencer
